// File: rtl/step_checker_pkg.sv
// Shared definitions for step_checker: step-code constants, execute-group table,
// code classes and the phase encoding reported on the phase output.
package step_checker_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_FETCH = 2'd1,
        PH_EXEC  = 2'd2,
        PH_HALT  = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_FETCH   = 3'd1,
        CL_START   = 3'd2,
        CL_SINGLE  = 3'd3,
        CL_BUBBLE  = 3'd4,
        CL_HALT    = 3'd5
    } step_class_t;

    localparam int LEN_W = 3;

    localparam int CODE_FETCH1 = 1;
    localparam int CODE_FETCH2 = 2;
    localparam int CODE_FETCH3 = 3;
    localparam int CODE_BUBBLE = 56;
    localparam int CODE_HALT   = 57;

    localparam int SINGLE_LO = 36;
    localparam int SINGLE_HI = 51;

    // Branch 52 is a two-step group (52,53); 54 is the one-step branch form.
    localparam int NUM_GROUPS = 12;
    localparam int GRP_START [0:NUM_GROUPS-1] = '{4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33, 52};
    localparam int GRP_LEN   [0:NUM_GROUPS-1] = '{4, 4,  2,  2,  2,  3,  3,  3,  3,  3,  3,  2};

    function automatic logic is_single(input int code);
        return (code >= SINGLE_LO && code <= SINGLE_HI) ||
               code == 54 || code == 55 || code == 58 || code == 59;
    endfunction

endpackage

// File: rtl/step_checker_lut.sv
// step_lut: combinational map from a step code to its class and group length
// (group length is 1 for single-step codes, 0 for non-step codes).
module step_lut
    import step_checker_pkg::*;
#(
    parameter int SM_SIG_LEN = 6
) (
    input  logic [SM_SIG_LEN-1:0] code,
    output step_class_t           cls,
    output logic [LEN_W-1:0]      grp_len
);

    int code_w;
    assign code_w = int'(code);

    always_comb begin
        cls     = CL_ILLEGAL;
        grp_len = '0;
        if (code_w == CODE_FETCH1 || code_w == CODE_FETCH2 || code_w == CODE_FETCH3) begin
            cls = CL_FETCH;
        end else if (code_w == CODE_BUBBLE) begin
            cls = CL_BUBBLE;
        end else if (code_w == CODE_HALT) begin
            cls = CL_HALT;
        end else if (is_single(code_w)) begin
            cls     = CL_SINGLE;
            grp_len = LEN_W'(1);
        end else begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                if (code_w == GRP_START[i]) begin
                    cls     = CL_START;
                    grp_len = LEN_W'(GRP_LEN[i]);
                end
            end
        end
    end

endmodule

// File: rtl/step_checker.sv
// step_checker: checks the step-code stream for legal fetch/execute sequencing,
// counts retired instructions. Define STEP_PERF_EN to add the bubble counter.
//
// state    | meaning
// PH_IDLE  | waiting for fetch code 1
// PH_FETCH | fetch in progress, expecting 2 then 3
// PH_EXEC  | awaiting a group start/single step (remain=0) or next group step
// PH_HALT  | halt accepted; everything ignored until reset
module step_checker
    import step_checker_pkg::*;
#(
    parameter int SM_SIG_LEN = 6,
    parameter int CNT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SM_SIG_LEN-1:0] smInput,
    output logic                  step_valid,
    output logic                  retire,
    output logic [CNT_LEN-1:0]    instr_count,
    output logic                  seq_err,
    output logic [SM_SIG_LEN-1:0] err_code,
    output logic                  halted,
    output logic [1:0]            phase,
    output logic [CNT_LEN-1:0]    bubble_count
);

    step_class_t           cls;
    logic [LEN_W-1:0]      grp_len;

    phase_t                state_q, state_d;
    logic [SM_SIG_LEN-1:0] expect_q, expect_d;
    logic [LEN_W-1:0]      remain_q, remain_d;
    logic                  step_valid_d, retire_d, err_d;
    logic                  step_valid_q, retire_q, seq_err_q;
    logic [SM_SIG_LEN-1:0] err_code_q;
    logic [CNT_LEN-1:0]    instr_count_q;

    step_lut #(.SM_SIG_LEN(SM_SIG_LEN)) u_lut (
        .code    (smInput),
        .cls     (cls),
        .grp_len (grp_len)
    );

    always_comb begin
        state_d      = state_q;
        expect_d     = expect_q;
        remain_d     = remain_q;
        step_valid_d = 1'b0;
        retire_d     = 1'b0;
        err_d        = 1'b0;
        if (cls != CL_BUBBLE) begin
            case (state_q)
                PH_IDLE: begin
                    if (smInput == SM_SIG_LEN'(CODE_FETCH1)) begin
                        step_valid_d = 1'b1;
                        expect_d     = SM_SIG_LEN'(CODE_FETCH2);
                        state_d      = PH_FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                PH_FETCH: begin
                    if (smInput == expect_q) begin
                        step_valid_d = 1'b1;
                        if (expect_q == SM_SIG_LEN'(CODE_FETCH3)) begin
                            state_d  = PH_EXEC;
                            remain_d = '0;
                        end else begin
                            expect_d = expect_q + SM_SIG_LEN'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                PH_EXEC: begin
                    // remain counts group steps still owed after the last accepted one
                    if (remain_q != '0) begin
                        if (smInput == expect_q) begin
                            step_valid_d = 1'b1;
                            if (remain_q == LEN_W'(1)) begin
                                retire_d = 1'b1;
                                remain_d = '0;
                                state_d  = PH_IDLE;
                            end else begin
                                remain_d = remain_q - LEN_W'(1);
                                expect_d = expect_q + SM_SIG_LEN'(1);
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (cls)
                            CL_START: begin
                                step_valid_d = 1'b1;
                                expect_d     = smInput + SM_SIG_LEN'(1);
                                remain_d     = grp_len - LEN_W'(1);
                            end
                            CL_SINGLE: begin
                                step_valid_d = 1'b1;
                                retire_d     = 1'b1;
                                state_d      = PH_IDLE;
                            end
                            CL_HALT: begin
                                step_valid_d = 1'b1;
                                retire_d     = 1'b1;
                                state_d      = PH_HALT;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
        if (err_d) begin
            state_d  = PH_IDLE;
            remain_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= PH_IDLE;
            expect_q      <= '0;
            remain_q      <= '0;
            step_valid_q  <= 1'b0;
            retire_q      <= 1'b0;
            seq_err_q     <= 1'b0;
            err_code_q    <= '0;
            instr_count_q <= '0;
        end else if (start) begin
            state_q      <= state_d;
            expect_q     <= expect_d;
            remain_q     <= remain_d;
            step_valid_q <= step_valid_d;
            retire_q     <= retire_d;
            if (err_d) begin
                seq_err_q <= 1'b1;
                if (!seq_err_q) err_code_q <= smInput;
            end
            if (retire_d && instr_count_q != '1) instr_count_q <= instr_count_q + CNT_LEN'(1);
        end else begin
            // pulses never stretch across a paused cycle
            step_valid_q <= 1'b0;
            retire_q     <= 1'b0;
        end
    end

`ifdef STEP_PERF_EN
    logic [CNT_LEN-1:0] bubble_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_q <= '0;
        end else if (start && cls == CL_BUBBLE && state_q != PH_HALT && bubble_q != '1) begin
            bubble_q <= bubble_q + CNT_LEN'(1);
        end
    end

    assign bubble_count = bubble_q;
`else
    assign bubble_count = '0;
`endif

    assign step_valid  = step_valid_q;
    assign retire      = retire_q;
    assign instr_count = instr_count_q;
    assign seq_err     = seq_err_q;
    assign err_code    = err_code_q;
    assign halted      = (state_q == PH_HALT);
    assign phase       = state_q;

endmodule

// File: tb/tb_step_checker.sv
// Testbench for step_checker: queue-based reference model compared every cycle,
// plus directed sequences with literal expectations and a saturation run.
module tb_step_checker;

    localparam int SW   = 6;
    localparam int CW   = 10;  // narrow counter so saturation is reachable in a short run
    localparam int CMAX = (1 << CW) - 1;
`ifdef STEP_PERF_EN
    localparam int BUB2 = 2;
`else
    localparam int BUB2 = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] smInput = '0;
    logic          step_valid, retire, seq_err, halted;
    logic [CW-1:0] instr_count, bubble_count;
    logic [SW-1:0] err_code;
    logic [1:0]    phase;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    step_checker #(.SM_SIG_LEN(SW), .CNT_LEN(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .smInput      (smInput),
        .step_valid   (step_valid),
        .retire       (retire),
        .instr_count  (instr_count),
        .seq_err      (seq_err),
        .err_code     (err_code),
        .halted       (halted),
        .phase        (phase),
        .bubble_count (bubble_count)
    );

    int g_start [12] = '{4, 8, 12, 14, 16, 18, 21, 24, 27, 30, 33, 52};
    int g_len   [12] = '{4, 4,  2,  2,  2,  3,  3,  3,  3,  3,  3,  2};
    int singles [$];

    // reference model: q holds the codes still owed by the current fetch or group
    int q [$];
    int mph       = 0;
    bit m_valid   = 0;
    bit m_retire  = 0;
    bit m_err     = 0;
    int m_errcode = 0;
    int m_count   = 0;
    int m_bub     = 0;

    function automatic int grp_len_of(input int c);
        for (int i = 0; i < 12; i++) if (c == g_start[i]) return g_len[i];
        if ((c >= 36 && c <= 51) || c == 54 || c == 55 || c == 58 || c == 59) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        q.delete();
        mph = 0; m_valid = 0; m_retire = 0; m_err = 0;
        m_errcode = 0; m_count = 0; m_bub = 0;
    endtask

    task automatic model_step(input bit st, input int c);
        bit ok, done, halt;
        int n;
        m_valid = 0;
        m_retire = 0;
        if (!st) return;
        if (c == 56) begin
            if (mph != 3 && m_bub < CMAX) m_bub++;
            return;
        end
        if (mph == 3) return;
        ok = 0; done = 0; halt = 0;
        if (mph == 0) begin
            if (c == 1) begin ok = 1; q.push_back(2); q.push_back(3); mph = 1; end
        end else if (mph == 1) begin
            if (c == q[0]) begin ok = 1; void'(q.pop_front()); if (q.size() == 0) mph = 2; end
        end else if (q.size() > 0) begin
            if (c == q[0]) begin ok = 1; void'(q.pop_front()); done = (q.size() == 0); end
        end else if (c == 57) begin
            ok = 1; done = 1; halt = 1;
        end else begin
            n = grp_len_of(c);
            if (n > 0) begin
                ok = 1;
                for (int k = 1; k < n; k++) q.push_back(c + k);
                done = (n == 1);
            end
        end
        if (ok) begin
            m_valid = 1;
            if (done) begin
                m_retire = 1;
                if (m_count < CMAX) m_count++;
                mph = halt ? 3 : 0;
            end
        end else begin
            if (!m_err) m_errcode = c;
            m_err = 1;
            mph = 0;
            q.delete();
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step(start, int'(smInput));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int exp_bub;
`ifdef STEP_PERF_EN
        exp_bub = m_bub;
`else
        exp_bub = 0;
`endif
        chk("step_valid", step_valid, m_valid);
        chk("retire", retire, m_retire);
        chk("instr_count", instr_count, m_count);
        chk("seq_err", seq_err, m_err);
        chk("err_code", err_code, m_errcode);
        chk("halted", halted, mph == 3);
        chk("phase", phase, mph);
        chk("bubble_count", bubble_count, exp_bub);
    end

    task automatic drive(input bit st, input int c);
        @(posedge clk);
        #2;
        start   = st;
        smInput = SW'(c);
    endtask

    task automatic send(input int codes [$]);
        foreach (codes[i]) drive(1'b1, codes[i]);
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic emit(input int c);
        int code;
        code = c;
        if ($urandom_range(0, 9) == 0) drive(1'b1, 56);
        if ($urandom_range(0, 9) == 0) drive(1'b0, int'($urandom_range(0, 63)));
        if ($urandom_range(0, 29) == 0) code = int'($urandom_range(0, 63));
        drive(1'b1, code);
    endtask

    initial begin
        int s [$];
        int r, gi;
        for (int v = 36; v <= 51; v++) singles.push_back(v);
        singles.push_back(54); singles.push_back(55);
        singles.push_back(58); singles.push_back(59);

        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        peek();
        chk("rst_phase", phase, 0);
        chk("rst_count", instr_count, 0);
        chk("rst_seq_err", seq_err, 0);

        // plain four-step group
        do_reset();
        s = '{1, 2, 3, 4, 5, 6, 7}; send(s);
        drive(1'b0, 0); peek();
        chk("g4_retire", retire, 1);
        chk("g4_count", instr_count, 1);
        chk("g4_seq_err", seq_err, 0);

        // branch group with interleaved bubbles
        do_reset();
        s = '{1, 2, 3, 52, 56, 53}; send(s);
        drive(1'b1, 56); peek();
        chk("br_retire", retire, 1);
        drive(1'b0, 0); peek();
        chk("br_bubble_valid", step_valid, 0);
        chk("br_bubble_count", bubble_count, BUB2);

        // out-of-order fetch, then recovery
        do_reset();
        s = '{1, 3}; send(s);
        drive(1'b0, 0); peek();
        chk("err_flag", seq_err, 1);
        chk("err_code", err_code, 3);
        chk("err_phase", phase, 0);
        s = '{1, 2, 3, 36}; send(s);
        drive(1'b0, 0); peek();
        chk("rec_retire", retire, 1);
        chk("rec_seq_err", seq_err, 1);
        chk("rec_err_code", err_code, 3);

        // halt then ignored fetch
        do_reset();
        s = '{1, 2, 3, 57, 1}; send(s);
        drive(1'b0, 0); peek();
        chk("halt_halted", halted, 1);
        chk("halt_phase", phase, 3);
        chk("halt_count", instr_count, 1);
        chk("halt_ignore", step_valid, 0);

        // pause mid-group
        do_reset();
        s = '{1, 2, 3, 8, 9}; send(s);
        repeat (3) drive(1'b0, 0);
        s = '{10, 11}; send(s);
        drive(1'b0, 0); peek();
        chk("pause_retire", retire, 1);
        chk("pause_count", instr_count, 1);
        chk("pause_seq_err", seq_err, 0);

        // asynchronous reset mid-group
        do_reset();
        s = '{1, 2, 3, 8, 9}; send(s);
        drive(1'b0, 0);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", step_valid, 0);
        chk("arst_phase", phase, 0);
        chk("arst_retire", retire, 0);
        chk("arst_seq_err", seq_err, 0);
        @(posedge clk);
        #2 reset = 1'b1;

        // randomized instruction streams
        for (int n = 0; n < 600; n++) begin
            emit(1); emit(2); emit(3);
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                gi = int'($urandom_range(0, 11));
                for (int k = 0; k < g_len[gi]; k++) emit(g_start[gi] + k);
            end else if (r < 95) begin
                emit(singles[$urandom_range(0, singles.size() - 1)]);
            end else begin
                emit(57);
            end
            if (r >= 95 || $urandom_range(0, 49) == 0) do_reset();
        end

        // counter saturation
        do_reset();
        for (int n = 0; n < CMAX; n++) begin
            s = '{1, 2, 3, 36}; send(s);
        end
        drive(1'b0, 0); peek();
        chk("sat_full", instr_count, CMAX);
        s = '{1, 2, 3, 40}; send(s);
        drive(1'b0, 0); peek();
        chk("sat_retire", retire, 1);
        chk("sat_hold", instr_count, CMAX);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
